regfile_wr_arbiter: RTL and testbench

// Shares the single write port of the 32x32 register file between pipeline writeback
// and a multi-cycle unit (MCU, e.g. mul/div) via a small MCU write FIFO. Writeback

---
 rtl/regfile_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file: writeback wins, MCU results queue in a FIFO.
// Optional post-reset zeroing sequence is enabled with `define RF_CLEAR_EN.
module regfile_wr_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mcu_valid_i,
  input  logic [4:0]  mcu_addr_i,
  input  logic [31:0] mcu_data_i,
  output logic        mcu_ready_o,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic        hazard_rs_o,
  output logic        hazard_rt_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        wr_en_o,
  output logic [4:0]  wr_addr_o,
  output logic [31:0] wr_data_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt, starve_nxt;
  logic             run, clearing;
  logic [4:0]       clr_cnt;
  logic             full, grant_pipe, pop, push;

`ifdef RF_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t     state, state_nxt;
  logic [4:0] clr_cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= CLEAR;
      clr_cnt <= 5'd0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 5'd1;
        if (clr_cnt == 5'd31) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  assign run      = (state == RUN);
  assign clearing = (state == CLEAR);
  assign busy_o   = clearing;
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign clr_cnt  = 5'd0;
  assign busy_o   = 1'b0;
`endif

  // Readiness uses the start-of-cycle count, so a same-cycle pop never frees a slot early.
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign mcu_ready_o = run && !full;
  assign grant_pipe  = run && pipe_we_i && (pipe_addr_i != 5'd0);
  assign pop         = run && !grant_pipe && (count != '0);
  assign push        = mcu_valid_i && mcu_ready_o && (mcu_addr_i != 5'd0);

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || count == '0)
      starve_nxt = '0;
    else if (grant_pipe && starve_cnt < STV_W'(STARVE_LIMIT))
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mcu_addr_i;
      fifo_data[wr_ptr] <= mcu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      stall_o    <= 1'b0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= 5'd0;
      wr_data_o  <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      starve_cnt <= starve_nxt;
      stall_o    <= (starve_nxt >= STV_W'(STARVE_LIMIT));
      if (clearing) begin
        wr_en_o   <= 1'b1;
        wr_addr_o <= clr_cnt;
        wr_data_o <= 32'd0;
      end else if (grant_pipe) begin
        wr_en_o   <= 1'b1;
        wr_addr_o <= pipe_addr_i;
        wr_data_o <= pipe_data_i;
      end else if (pop) begin
        wr_en_o   <= 1'b1;
        wr_addr_o <= fifo_addr[rd_ptr];
        wr_data_o <= fifo_data[rd_ptr];
      end else begin
        wr_en_o   <= 1'b0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  logic [PTR_W-1:0]      offs [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entry_vld, match_rs, match_rt;

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs[i]      = PTR_W'(i) - rd_ptr;
      entry_vld[i] = ({1'b0, offs[i]} < count);
      match_rs[i]  = (fifo_addr[i] == rs_addr_i);
      match_rt[i]  = (fifo_addr[i] == rt_addr_i);
    end
  end

  assign hazard_rs_o = (rs_addr_i != 5'd0) &&
                       (|(entry_vld & match_rs) || (wr_en_o && wr_addr_o == rs_addr_i));
  assign hazard_rt_o = (rt_addr_i != 5'd0) &&
                       (|(entry_vld & match_rt) || (wr_en_o && wr_addr_o == rt_addr_i));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, ordering, FIFO back-pressure, r0, hazards.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mcu_valid;
  logic [4:0]  mcu_addr;
  logic [31:0] mcu_data;
  logic        mcu_ready;
  logic [4:0]  rs_addr, rt_addr;
  logic        hazard_rs, hazard_rt, stall, busy, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

`ifdef RF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  regfile_wr_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_we_i(pipe_we), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .mcu_valid_i(mcu_valid), .mcu_addr_i(mcu_addr), .mcu_data_i(mcu_data),
    .mcu_ready_o(mcu_ready),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .hazard_rs_o(hazard_rs), .hazard_rt_o(hazard_rt),
    .stall_o(stall), .busy_o(busy),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pipe_we = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    mcu_valid = 1'b0; mcu_addr = 5'd0; mcu_data = 32'd0;
    rs_addr = 5'd5; rt_addr = 5'd0;
    step(); step();
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== 38'd0) begin
      n_err++; $display("FAIL reset_wr got en=%b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data);
    end
    n_vec++;
    if (stall !== 1'b0 || hazard_rs !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got stall=%b hz_rs=%b want 0/0", stall, hazard_rs);
    end
    n_vec++;
    if (busy !== CLR || mcu_ready !== !CLR) begin
      n_err++; $display("FAIL reset_state got busy=%b ready=%b want %b/%b", busy, mcu_ready, CLR, !CLR);
    end
    rst = 1'b0;
  endtask

`ifdef RF_CLEAR_EN
  task automatic test_clear();
    for (int k = 1; k <= 10; k++) begin
      step();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(k - 1) || wr_data !== 32'd0 || busy !== 1'b1) begin
        n_err++; $display("FAIL clear_pre k=%0d got en=%b addr=%0d data=%h busy=%b want 1/%0d/0/1",
                          k, wr_en, wr_addr, wr_data, busy, k - 1);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(k - 1) || wr_data !== 32'd0 || busy !== (k < 32)) begin
        n_err++; $display("FAIL clear_seq k=%0d got en=%b addr=%0d data=%h busy=%b want 1/%0d/0/%b",
                          k, wr_en, wr_addr, wr_data, busy, k - 1, k < 32);
      end
    end
    step();
    n_vec++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || mcu_ready !== 1'b1) begin
      n_err++; $display("FAIL clear_done got en=%b busy=%b ready=%b want 0/0/1", wr_en, busy, mcu_ready);
    end
  endtask
`endif

  task automatic test_same_cycle();
    pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h1234;
    mcu_valid = 1'b1; mcu_addr = 5'd7; mcu_data = 32'hABCD;
    n_vec++;
    if (mcu_ready !== 1'b1) begin
      n_err++; $display("FAIL same_ready got %b want 1", mcu_ready);
    end
    step();
    pipe_we = 1'b0; mcu_valid = 1'b0;
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h1234) begin
      n_err++; $display("FAIL same_wb got en=%b addr=%0d data=%h want 1/5/1234", wr_en, wr_addr, wr_data);
    end
    step();
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hABCD) begin
      n_err++; $display("FAIL same_mcu got en=%b addr=%0d data=%h want 1/7/abcd", wr_en, wr_addr, wr_data);
    end
    step();
    n_vec++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd7 || wr_data !== 32'hABCD) begin
      n_err++; $display("FAIL same_idle got en=%b addr=%0d data=%h want 0/7/abcd", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_starve();
    pipe_we = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h11;
    for (int k = 0; k < 5; k++) begin
      mcu_valid = 1'b1; mcu_addr = 5'(10 + k); mcu_data = 32'hA0 + k;
      n_vec++;
      if (mcu_ready !== (k < 4)) begin
        n_err++; $display("FAIL starve_ready k=%0d got %b want %b", k, mcu_ready, k < 4);
      end
      step();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== 32'h11) begin
        n_err++; $display("FAIL starve_wb k=%0d got en=%b addr=%0d data=%h want 1/1/11", k, wr_en, wr_addr, wr_data);
      end
    end
    mcu_valid = 1'b0;
    step(); step(); step();
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL starve_pre got stall=%b want 0", stall);
    end
    step();
    n_vec++;
    if (stall !== 1'b1 || wr_addr !== 5'd1) begin
      n_err++; $display("FAIL starve_stall got stall=%b addr=%0d want 1/1", stall, wr_addr);
    end
    pipe_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(10 + k) || wr_data !== 32'hA0 + k || stall !== 1'b0) begin
        n_err++; $display("FAIL starve_drain k=%0d got en=%b addr=%0d data=%h stall=%b want 1/%0d/%h/0",
                          k, wr_en, wr_addr, wr_data, stall, 10 + k, 32'hA0 + k);
      end
    end
    step();
    n_vec++;
    if (wr_en !== 1'b0 || mcu_ready !== 1'b1) begin
      n_err++; $display("FAIL starve_empty got en=%b ready=%b want 0/1", wr_en, mcu_ready);
    end
  endtask

  task automatic test_r0();
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hDEAD;
    mcu_valid = 1'b1; mcu_addr = 5'd0; mcu_data = 32'hBEEF;
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (mcu_ready !== 1'b1) begin
        n_err++; $display("FAIL r0_ready k=%0d got %b want 1", k, mcu_ready);
      end
      step();
      n_vec++;
      if (wr_en !== 1'b0) begin
        n_err++; $display("FAIL r0_wr k=%0d got en=%b addr=%0d want 0", k, wr_en, wr_addr);
      end
    end
    pipe_we = 1'b0; mcu_valid = 1'b0;
    step();
    n_vec++;
    if (wr_en !== 1'b0) begin
      n_err++; $display("FAIL r0_after got en=%b want 0", wr_en);
    end
  endtask

  task automatic test_hazard();
    rs_addr = 5'd9; rt_addr = 5'd0;
    n_vec++;
    if (hazard_rs !== 1'b0) begin
      n_err++; $display("FAIL hz_idle got %b want 0", hazard_rs);
    end
    pipe_we = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h22;
    mcu_valid = 1'b1; mcu_addr = 5'd9; mcu_data = 32'h99;
    step();
    mcu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) pipe_we = 1'b0;
      n_vec++;
      if (hazard_rs !== 1'b1 || hazard_rt !== 1'b0) begin
        n_err++; $display("FAIL hz_queued k=%0d got rs=%b rt=%b want 1/0", k, hazard_rs, hazard_rt);
      end
      step();
    end
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h99 || hazard_rs !== 1'b1 || hazard_rt !== 1'b0) begin
      n_err++; $display("FAIL hz_onport got en=%b addr=%0d data=%h rs=%b rt=%b want 1/9/99/1/0",
                        wr_en, wr_addr, wr_data, hazard_rs, hazard_rt);
    end
    step();
    n_vec++;
    if (hazard_rs !== 1'b0 || hazard_rt !== 1'b0 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL hz_after got rs=%b rt=%b en=%b want 0/0/0", hazard_rs, hazard_rt, wr_en);
    end
  endtask

  initial begin
    test_reset();
`ifdef RF_CLEAR_EN
    test_clear();
`endif
    test_same_cycle();
    test_starve();
    test_r0();
    test_hazard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
